nrf_spi_responder: RTL and testbench

//  SPI mode-0 target emulating the nRF24L01 register port, i.e. the far end of the team's SPI controller.

---
 rtl/nrf_spi_responder.sv | 202 ++++++++++++++++++++
 tb/tb_nrf_spi_responder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/nrf_spi_responder.sv
// SPI mode-0 target emulating the nRF24L01 register port (R_REGISTER/W_REGISTER/NOP).
// SCK/CSN/MOSI are oversampled on clk_50; the 32x8 register file is written only from SPI.
module nrf_spi_responder #(
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  RST_CONFIG  = 8'h08,
    parameter logic [7:0]  RST_STATUS  = 8'h0E
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic        sck,
    input  logic        csn,
    input  logic        mosi,
    output logic        miso,
    output logic        miso_oe,
    output logic        rx_valid,
    output logic [7:0]  rx_byte,
    output logic        wr_valid,
    output logic [4:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        cmd_err,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, CMD, RD, WR, NOPX, BAD} state_t;

    logic [SYNC_STAGES-1:0] sck_sync_q, csn_sync_q, mosi_sync_q;
    logic                   sck_prev_q, csn_prev_q;
    logic                   sck_s, csn_s, mosi_s;
    logic                   sck_rise, sck_fall, csn_rise, csn_fall;

    state_t      state_q, state_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [4:0]  ptr_q, ptr_d;
    logic [7:0]  rx_shift_q, rx_shift_d;
    logic [7:0]  tx_shift_q, tx_shift_d;
    logic [7:0]  next_q, next_d;
    logic        miso_oe_q, miso_oe_d;
    logic        rx_valid_q, rx_valid_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        wr_valid_q, wr_valid_d;
    logic [4:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        cmd_err_q, cmd_err_d;
    logic        wr_en;
    logic [7:0]  byte_in;
    logic [7:0]  regs_q [32];

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign csn_s    = csn_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_prev_q;
    assign sck_fall = ~sck_s & sck_prev_q;
    assign csn_rise = csn_s & ~csn_prev_q;
    assign csn_fall = ~csn_s & csn_prev_q;

    // CSN resets to the deasserted level so a select held low through reset is seen as a fall.
    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            sck_sync_q  <= '0;
            csn_sync_q  <= '1;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            csn_prev_q  <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], csn};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sck_prev_q  <= sck_s;
            csn_prev_q  <= csn_s;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 32; gi++) begin : g_reg
            localparam logic [7:0] RST_VAL = (gi == 0) ? RST_CONFIG :
                                             (gi == 7) ? RST_STATUS : 8'h00;
            always_ff @(posedge clk_50 or posedge rst) begin
                if (rst)
                    regs_q[gi] <= RST_VAL;
                else if (wr_en && ptr_q == 5'(gi))
                    regs_q[gi] <= byte_in;
            end
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        ptr_d      = ptr_q;
        rx_shift_d = rx_shift_q;
        tx_shift_d = tx_shift_q;
        next_d     = next_q;
        miso_oe_d  = miso_oe_q;
        rx_byte_d  = rx_byte_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rx_valid_d = 1'b0;
        wr_valid_d = 1'b0;
        cmd_err_d  = 1'b0;
        wr_en      = 1'b0;
        byte_in    = {rx_shift_q[6:0], mosi_s};

        if (csn_fall) begin
            state_d    = CMD;
            tx_shift_d = regs_q[7];
            miso_oe_d  = 1'b1;
            bit_cnt_d  = 3'd0;
            next_d     = 8'h00;
        end else begin
            if (state_q != IDLE && sck_rise) begin
                rx_shift_d = byte_in;
                bit_cnt_d  = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    rx_valid_d = 1'b1;
                    rx_byte_d  = byte_in;
                    next_d     = 8'h00;
                    case (state_q)
                        CMD: begin
                            if (byte_in[7:5] == 3'b000) begin
                                state_d = RD;
                                next_d  = regs_q[byte_in[4:0]];
                                ptr_d   = byte_in[4:0] + 5'd1;
                            end else if (byte_in[7:5] == 3'b001) begin
                                state_d = WR;
                                ptr_d   = byte_in[4:0];
                            end else if (byte_in == 8'hFF) begin
                                state_d = NOPX;
                            end else begin
                                state_d   = BAD;
                                cmd_err_d = 1'b1;
                            end
                        end
                        RD: begin
                            next_d = regs_q[ptr_q];
                            ptr_d  = ptr_q + 5'd1;
                        end
                        WR: begin
                            wr_en      = 1'b1;
                            wr_valid_d = 1'b1;
                            wr_addr_d  = ptr_q;
                            wr_data_d  = byte_in;
                            ptr_d      = ptr_q + 5'd1;
                        end
                        default: ;
                    endcase
                end
            end
            if (state_q != IDLE && sck_fall)
                tx_shift_d = (bit_cnt_q == 3'd0) ? next_q : {tx_shift_q[6:0], 1'b0};
            // A byte completing in the same cycle as CSN rise has already been committed above.
            if (csn_rise) begin
                state_d   = IDLE;
                miso_oe_d = 1'b0;
                bit_cnt_d = 3'd0;
            end
        end
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 3'd0;
            ptr_q      <= 5'd0;
            rx_shift_q <= 8'h00;
            tx_shift_q <= 8'h00;
            next_q     <= 8'h00;
            miso_oe_q  <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_byte_q  <= 8'h00;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 5'd0;
            wr_data_q  <= 8'h00;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            ptr_q      <= ptr_d;
            rx_shift_q <= rx_shift_d;
            tx_shift_q <= tx_shift_d;
            next_q     <= next_d;
            miso_oe_q  <= miso_oe_d;
            rx_valid_q <= rx_valid_d;
            rx_byte_q  <= rx_byte_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

    assign miso     = tx_shift_q[7] & miso_oe_q;
    assign miso_oe  = miso_oe_q;
    assign rx_valid = rx_valid_q;
    assign rx_byte  = rx_byte_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign cmd_err  = cmd_err_q;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_nrf_spi_responder.sv
// Bench for nrf_spi_responder: an SPI master model drives register transactions,
// a scoreboard queue holds the expected received bytes and register writes.
module tb_nrf_spi_responder;

    localparam int HALF = 8;

    typedef logic [7:0] bytes3_t [3];
    typedef struct {
        logic [7:0] b0, b1;
        logic [7:0] m0, m1;
        logic       wr;
        logic [4:0] wa;
        logic [7:0] wd;
    } vec_t;

    logic       clk_50 = 1'b0;
    logic       rst, sck, csn, mosi;
    logic       miso, miso_oe, rx_valid, wr_valid, cmd_err, busy;
    logic [7:0] rx_byte, wr_data;
    logic [4:0] wr_addr;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int err_cnt = 0;

    logic [7:0]  exp_rx [$];
    logic [7:0]  exp_miso [$];
    logic [12:0] exp_wr [$];

    nrf_spi_responder dut (
        .clk_50  (clk_50),
        .rst     (rst),
        .sck     (sck),
        .csn     (csn),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .rx_valid(rx_valid),
        .rx_byte (rx_byte),
        .wr_valid(wr_valid),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .cmd_err (cmd_err),
        .busy    (busy)
    );

    always #10 clk_50 = ~clk_50;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    // Monitor: pops expected rx bytes and writes as the DUT reports them.
    always @(negedge clk_50) begin
        if (!rst) begin
            if (rx_valid) begin
                if (exp_rx.size() == 0) chk("rx_unexpected", 32'd1, 32'd0);
                else chk("rx_byte", {24'd0, rx_byte}, {24'd0, exp_rx.pop_front()});
            end
            if (wr_valid) begin
                wr_cnt++;
                if (exp_wr.size() == 0) chk("wr_unexpected", 32'd1, 32'd0);
                else chk("wr_addr_data", {19'd0, wr_addr, wr_data}, {19'd0, exp_wr.pop_front()});
            end
            if (cmd_err) err_cnt++;
        end
    end

    task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[7-i];
            repeat (HALF) @(negedge clk_50);
            rx = {rx[6:0], miso};
            sck = 1'b1;
            repeat (HALF) @(negedge clk_50);
            sck = 1'b0;
        end
    endtask

    task automatic run_txn(input int n, input bytes3_t b, input bytes3_t m);
        logic [7:0] got;
        csn = 1'b0;
        repeat (HALF) @(negedge clk_50);
        for (int i = 0; i < n; i++) begin
            exp_rx.push_back(b[i]);
            exp_miso.push_back(m[i]);
            spi_bits(b[i], 8, got);
            chk("miso_byte", {24'd0, got}, {24'd0, exp_miso.pop_front()});
        end
        repeat (HALF) @(negedge clk_50);
        csn = 1'b1;
        repeat (2*HALF) @(negedge clk_50);
    endtask

    initial begin
        vec_t    tbl [8];
        bytes3_t b, m;
        logic [7:0] junk;
        int      err0, wr0;

        tbl[0] = '{8'h20, 8'h0B, 8'h0E, 8'h00, 1'b1, 5'h00, 8'h0B};
        tbl[1] = '{8'h00, 8'hFF, 8'h0E, 8'h0B, 1'b0, 5'h00, 8'h00};
        tbl[2] = '{8'h3F, 8'h5A, 8'h0E, 8'h00, 1'b1, 5'h1F, 8'h5A};
        tbl[3] = '{8'h07, 8'hFF, 8'h0E, 8'h0E, 1'b0, 5'h00, 8'h00};
        tbl[4] = '{8'hFF, 8'hFF, 8'h0E, 8'h00, 1'b0, 5'h00, 8'h00};
        tbl[5] = '{8'h32, 8'h81, 8'h0E, 8'h00, 1'b1, 5'h12, 8'h81};
        tbl[6] = '{8'h12, 8'h00, 8'h0E, 8'h81, 1'b0, 5'h00, 8'h00};
        tbl[7] = '{8'h05, 8'hFF, 8'h0E, 8'h00, 1'b0, 5'h00, 8'h00};

        rst = 1'b1; csn = 1'b0; sck = 1'b0; mosi = 1'b0;
        repeat (4) @(negedge clk_50);
        chk("rst_miso", {31'd0, miso}, 32'd0);
        chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
        chk("rst_pulses", {29'd0, rx_valid, wr_valid, cmd_err}, 32'd0);
        rst = 1'b0;

        // csn held low through reset: one NOP byte returns STATUS.
        err0 = err_cnt;
        b = '{8'hFF, 8'h00, 8'h00}; m = '{8'h0E, 8'h00, 8'h00};
        run_txn(1, b, m);
        chk("t1_cmd_err", err_cnt - err0, 32'd0);
        chk("t1_no_write", wr_cnt, 32'd0);

        for (int i = 0; i < 8; i++) begin
            if (tbl[i].wr) exp_wr.push_back({tbl[i].wa, tbl[i].wd});
            b = '{tbl[i].b0, tbl[i].b1, 8'h00};
            m = '{tbl[i].m0, tbl[i].m1, 8'h00};
            run_txn(2, b, m);
        end
        chk("tbl_wr_count", wr_cnt, 32'd3);

        // Read wraps from 0x1F to 0x00.
        b = '{8'h1F, 8'h00, 8'h00}; m = '{8'h0E, 8'h5A, 8'h0B};
        run_txn(3, b, m);

        // Write aborted after 4 data bits.
        wr0 = wr_cnt;
        csn = 1'b0;
        repeat (HALF) @(negedge clk_50);
        exp_rx.push_back(8'h25);
        spi_bits(8'h25, 8, junk);
        chk("t4_status", {24'd0, junk}, 32'h0E);
        spi_bits(8'hF0, 4, junk);
        csn = 1'b1;
        repeat (4) @(negedge clk_50);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        repeat (2*HALF) @(negedge clk_50);
        chk("t4_no_write", wr_cnt - wr0, 32'd0);
        b = '{8'h05, 8'hFF, 8'h00}; m = '{8'h0E, 8'h00, 8'h00};
        run_txn(2, b, m);

        // Unsupported command.
        err0 = err_cnt;
        b = '{8'h50, 8'hAA, 8'h55}; m = '{8'h0E, 8'h00, 8'h00};
        run_txn(3, b, m);
        chk("t5_cmd_err", err_cnt - err0, 32'd1);
        b = '{8'h00, 8'hFF, 8'h00}; m = '{8'h0E, 8'h0B, 8'h00};
        run_txn(2, b, m);

        // Reset mid-byte reverts the register file.
        exp_wr.push_back({5'h03, 8'hAA});
        b = '{8'h23, 8'hAA, 8'h00}; m = '{8'h0E, 8'h00, 8'h00};
        run_txn(2, b, m);
        csn = 1'b0;
        repeat (HALF) @(negedge clk_50);
        spi_bits(8'h03, 3, junk);
        rst = 1'b1;
        @(negedge clk_50);
        chk("t6_miso_oe", {31'd0, miso_oe}, 32'd0);
        chk("t6_busy", {31'd0, busy}, 32'd0);
        chk("t6_rx_byte", {24'd0, rx_byte}, 32'd0);
        chk("t6_miso", {31'd0, miso}, 32'd0);
        csn = 1'b1;
        repeat (4) @(negedge clk_50);
        rst = 1'b0;
        repeat (4) @(negedge clk_50);
        b = '{8'h03, 8'hFF, 8'h00}; m = '{8'h0E, 8'h00, 8'h00};
        run_txn(2, b, m);
        b = '{8'h00, 8'hFF, 8'h00}; m = '{8'h0E, 8'h08, 8'h00};
        run_txn(2, b, m);

        chk("rx_queue_empty", exp_rx.size(), 32'd0);
        chk("wr_queue_empty", exp_wr.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
